// File: rtl/riscv_pkg.sv
// Shared writeback-path definitions: default requester count and data width,
// requester index constants and the writeback request payload.
// Optional feature macro used by the writeback arbiter: REGFILE_WB_PERF_EN.
package riscv_pkg;

    localparam int unsigned DEF_NUM_REQ = 3;
    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned RD_W        = 5;
    localparam int unsigned CNT_W       = 16;

    // Writeback requester indices
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_CSR = 2;

    // Writeback request payload at the default data width
    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [DEF_XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
// Signals:
//   req_valid/req_rd/req_data  per-requester write request (requester -> arbiter)
//   req_ready                  one-hot grant, combinational (arbiter -> requester)
//   rd/rd_write_control/rd_write_val  registered register-file write port
//   conflict                   two or more requests pending this cycle
//   wait_cnt                   per-requester stall counters (REGFILE_WB_PERF_EN only)
// Modports: master = requester/register-file side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = riscv_pkg::DEF_NUM_REQ,
    parameter int unsigned XLEN    = riscv_pkg::DEF_XLEN
);
    import riscv_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][RD_W-1:0]  req_rd;
    logic [NUM_REQ-1:0][XLEN-1:0]  req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [RD_W-1:0]               rd;
    logic                          rd_write_control;
    logic [XLEN-1:0]               rd_write_val;
    logic                          conflict;

`ifdef REGFILE_WB_PERF_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, rd, rd_write_control, rd_write_val, conflict, wait_cnt
    );
    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, rd, rd_write_control, rd_write_val, conflict, wait_cnt
    );
`else
    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, rd, rd_write_control, rd_write_val, conflict
    );
    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, rd, rd_write_control, rd_write_val, conflict
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// searching upward with wrap; the pointer moves past the winner on a grant.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-low reset (pointer returns to 0)
//   req_i   request vector
//   gnt_c   one-hot or zero grant, combinational
module rr_arbiter #(
    parameter int unsigned NUM_REQ = riscv_pkg::DEF_NUM_REQ
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_c
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Wide enough for ptr + offset before the modulo fold
    localparam int unsigned CND_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic [CND_W-1:0] cand;
    logic             found;

    // Grant search and pointer advance
    always_comb begin
        gnt_c   = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        ptr_d   = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CND_W'(k);
            if (cand >= CND_W'(NUM_REQ)) begin
                cand = cand - CND_W'(NUM_REQ);
            end
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found                  = 1'b1;
                win_idx                = cand[PTR_W-1:0];
                gnt_c[cand[PTR_W-1:0]] = 1'b1;
            end
        end
        if (found) begin
            ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    // Pointer register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: picks one of NUM_REQ writeback requests per
// cycle round-robin and drives the register-file write port one cycle later.
// Writes to x0 are accepted but never enabled.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-low reset
//   bus     regfile_wb_arbiter_if.slave (requests, grant, write port, conflict)
// Optional feature: define REGFILE_WB_PERF_EN to add saturating per-requester
// wait counters on bus.wait_cnt.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned XLEN    = DEF_XLEN
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    regfile_wb_arbiter_if.slave   bus
);

    // Same layout as wb_req_t, sized by this instance's XLEN
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_pl_t;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt;
    wb_pl_t             win_pl;
    wb_pl_t             pl_q, pl_d;
    logic               we_q, we_d;

    // No grants while reset is held
    assign req_vec = bus.req_valid & {NUM_REQ{i_rst}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .req_i (req_vec),
        .gnt_c (gnt)
    );

    assign bus.req_ready = gnt;
    // More than one bit set <=> clearing the lowest set bit leaves something
    assign bus.conflict  = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

    // Winner payload mux
    always_comb begin
        win_pl = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_pl = '{rd: bus.req_rd[i], data: bus.req_data[i]};
            end
        end
    end

    // Write port next state: capture on transfer, hold payload when idle
    always_comb begin
        pl_d = pl_q;
        we_d = 1'b0;
        if (|gnt) begin
            pl_d = win_pl;
            we_d = (win_pl.rd != '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pl_q <= '0;
            we_q <= 1'b0;
        end else begin
            pl_q <= pl_d;
            we_q <= we_d;
        end
    end

    assign bus.rd               = pl_q.rd;
    assign bus.rd_write_val     = pl_q.data;
    assign bus.rd_write_control = we_q;

`ifdef REGFILE_WB_PERF_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] wait_q, wait_d;

    // Count stalled cycles per requester, saturating
    always_comb begin
        wait_d = wait_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && !gnt[i] && (wait_q[i] != '1)) begin
                wait_d[i] = wait_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign bus.wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a round-robin model.
module tb_regfile_wb_arbiter;
    import riscv_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned XL = 32;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .XLEN(XL)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int      m_ptr = 0;
    wb_req_t m_pl  = '0;
    logic    m_we  = 1'b0;
    int      model_gnt;

    // First valid index at or after ptr, wrapping; -1 when none or in reset
    function automatic int pick(input logic [N-1:0] v, input int ptr, input logic rst_n);
        if (!rst_n) return -1;
        for (int k = 0; k < int'(N); k++) begin
            if (v[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always_comb model_gnt = pick(bus.req_valid, m_ptr, i_rst);

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_ptr <= 0;
            m_pl  <= '0;
            m_we  <= 1'b0;
        end else if (model_gnt >= 0) begin
            m_pl  <= '{rd: bus.req_rd[model_gnt], data: bus.req_data[model_gnt]};
            m_we  <= (bus.req_rd[model_gnt] != 5'd0);
            m_ptr <= (model_gnt + 1) % int'(N);
        end else begin
            m_we  <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge i_clk) begin
        chk("req_ready",        64'(bus.req_ready),        64'(onehot(model_gnt)));
        chk("conflict",         64'(bus.conflict),         64'($countones(bus.req_valid) >= 2));
        chk("rd",               64'(bus.rd),               64'(m_pl.rd));
        chk("rd_write_control", 64'(bus.rd_write_control), 64'(m_we));
        chk("rd_write_val",     64'(bus.rd_write_val),     64'(m_pl.data));
    end

    // Requester rule: a pending request stays stable until it transfers
    logic [N-1:0]        pend = '0;
    logic [N-1:0][4:0]   pend_rd;
    logic [N-1:0][XL-1:0] pend_data;

    always @(posedge i_clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (pend[i] && i_rst) begin
                assert (bus.req_valid[i] && bus.req_rd[i] == pend_rd[i] &&
                        bus.req_data[i] == pend_data[i])
                else $error("requester %0d changed a pending request", i);
            end
            pend[i]      <= i_rst && bus.req_valid[i] && !bus.req_ready[i];
            pend_rd[i]   <= bus.req_rd[i];
            pend_data[i] <= bus.req_data[i];
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [XL-1:0] d);
        bus.req_rd[i]   = r;
        bus.req_data[i] = d;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;

        // Reset with all three requesters already valid
        set_req(0, 5'd1, 32'h0000_00A0);
        set_req(1, 5'd2, 32'h0000_00B1);
        set_req(2, 5'd3, 32'h0000_00C2);
        bus.req_valid = 3'b111;
        @(negedge i_clk);
        chk("rst_ready",   64'(bus.req_ready), 64'(3'b000));
        chk("rst_rd",      64'(bus.rd), 64'd0);
        chk("rst_we",      64'(bus.rd_write_control), 64'd0);
        chk("rst_val",     64'(bus.rd_write_val), 64'd0);
        @(posedge i_clk);
        #2 i_rst = 1'b1;

        // Three-way contention: grants 0,1,2
        @(negedge i_clk);
        chk("c3_g0",       64'(bus.req_ready), 64'(3'b001));
        chk("c3_conf0",    64'(bus.conflict), 64'd1);
        step();
        bus.req_valid = 3'b110;
        @(negedge i_clk);
        chk("c3_g1",       64'(bus.req_ready), 64'(3'b010));
        chk("c3_conf1",    64'(bus.conflict), 64'd1);
        chk("c3_rd0",      64'(bus.rd), 64'd1);
        chk("c3_val0",     64'(bus.rd_write_val), 64'h0000_00A0);
        step();
        bus.req_valid = 3'b100;
        @(negedge i_clk);
        chk("c3_g2",       64'(bus.req_ready), 64'(3'b100));
        chk("c3_conf2",    64'(bus.conflict), 64'd0);
        chk("c3_rd1",      64'(bus.rd), 64'd2);

        // Single request
        step();
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        bus.req_valid = 3'b001;
        @(negedge i_clk);
        chk("single_ready", 64'(bus.req_ready), 64'(3'b001));
        chk("c3_val2",      64'(bus.rd_write_val), 64'h0000_00C2);
`ifdef REGFILE_WB_PERF_EN
        chk("wait_cnt2",    64'(bus.wait_cnt[2]), 64'd2);
        chk("wait_cnt1",    64'(bus.wait_cnt[1]), 64'd1);
        chk("wait_cnt0",    64'(bus.wait_cnt[0]), 64'd0);
`endif
        step();
        bus.req_valid = 3'b000;
        @(negedge i_clk);
        chk("single_rd",    64'(bus.rd), 64'd5);
        chk("single_we",    64'(bus.rd_write_control), 64'd1);
        chk("single_val",   64'(bus.rd_write_val), 64'hDEAD_BEEF);

        // Idle cycle, then bring the pointer to 2
        step();
        set_req(1, 5'd7, 32'h0000_0077);
        bus.req_valid = 3'b010;
        @(negedge i_clk);
        chk("idle_we",      64'(bus.rd_write_control), 64'd0);
        chk("idle_rd_hold", 64'(bus.rd), 64'd5);
        chk("idle_val_hold",64'(bus.rd_write_val), 64'hDEAD_BEEF);

        // Wrap-around: ptr=2, valid=011 -> 0 then 1
        step();
        set_req(0, 5'd8, 32'h0000_0088);
        set_req(1, 5'd9, 32'h0000_0099);
        bus.req_valid = 3'b011;
        @(negedge i_clk);
        chk("wrap_g0",      64'(bus.req_ready), 64'(3'b001));
        step();
        bus.req_valid = 3'b010;
        @(negedge i_clk);
        chk("wrap_g1",      64'(bus.req_ready), 64'(3'b010));
        chk("wrap_rd0",     64'(bus.rd), 64'd8);
        step();
        set_req(2, 5'd12, 32'h0000_00CC);
        bus.req_valid = 3'b100;
        @(negedge i_clk);
        chk("wrap_ptr2",    64'(bus.req_ready), 64'(3'b100));

        // x0 discard
        step();
        set_req(1, 5'd0, 32'h0000_1234);
        bus.req_valid = 3'b010;
        @(negedge i_clk);
        chk("x0_ready",     64'(bus.req_ready), 64'(3'b010));
        chk("x0_prev_we",   64'(bus.rd_write_control), 64'd1);
        step();
        set_req(0, 5'd13, 32'h0000_0D13);
        bus.req_valid = 3'b001;
        @(negedge i_clk);
        chk("x0_we",        64'(bus.rd_write_control), 64'd0);
        chk("x0_val",       64'(bus.rd_write_val), 64'h0000_1234);

        // Reset in the cycle after a grant
        step();
        set_req(0, 5'd14, 32'h0000_0E14);
        set_req(1, 5'd15, 32'h0000_0F15);
        bus.req_valid = 3'b011;
        #1 i_rst = 1'b0;
        #1;
        chk("mid_rst_rd",    64'(bus.rd), 64'd0);
        chk("mid_rst_we",    64'(bus.rd_write_control), 64'd0);
        chk("mid_rst_val",   64'(bus.rd_write_val), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(3'b000));
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        @(negedge i_clk);
        chk("post_rst_g0",   64'(bus.req_ready), 64'(3'b001));
        step();
        bus.req_valid = 3'b010;
        @(negedge i_clk);
        chk("post_rst_rd",   64'(bus.rd), 64'd14);
        chk("post_rst_we",   64'(bus.rd_write_control), 64'd1);
        chk("post_rst_g1",   64'(bus.req_ready), 64'(3'b010));
        step();
        bus.req_valid = 3'b000;
        @(negedge i_clk);
        chk("post_rst_rd1",  64'(bus.rd), 64'd15);
        repeat (2) step();
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR); legal range 2..8.
REQ-002 SHALL have parameter XLEN, default 32, write data width.
REQ-003 SHALL have port i_clk  input  1  the block's single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-006 SHALL have port req_rd  input  NUM_REQ x 5  per-requester destination register index.
REQ-007 SHALL have port req_data  input  NUM_REQ x XLEN  per-requester write value.
REQ-008 SHALL have port req_ready  output  NUM_REQ  grant, one-hot or zero, combinational.
REQ-009 SHALL have port rd  output  5  registered write index driven to the register file.
REQ-010 SHALL have port rd_write_control  output  1  registered write enable driven to the register file.
REQ-011 SHALL have port rd_write_val  output  XLEN  registered write value driven to the register file.
REQ-012 SHALL have port conflict  output  1  combinational; high when two or more req_valid are high.

Function
REQ-013 SHALL transfer a request on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-014 SHALL assert at most one req_ready per cycle, and only to a requester with req_valid high.
REQ-015 SHALL assert some req_ready in every cycle where any req_valid is high (work-conserving).
REQ-016 SHALL pick the winner round-robin: the first valid index at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-017 SHALL set rr_ptr to (winner+1) mod NUM_REQ after every transfer, and leave it unchanged on idle cycles.
REQ-018 SHALL drive rd and rd_write_val with the winner's req_rd and req_data exactly one cycle after the transfer (latency 1).
REQ-019 SHALL set rd_write_control high in that same cycle, unless req_rd was 0.
REQ-020 SHALL accept a transfer with req_rd == 0 (ready still asserted) but drop it: rd_write_control stays 0.
REQ-021 SHALL drive rd_write_control low in the cycle after an idle cycle; rd and rd_write_val then hold their previous values.
REQ-022 SHALL impose a requester rule, checked by bench assertion: once req_valid[i] is raised, req_valid[i], req_rd[i] and req_data[i] stay stable until transfer.
REQ-023 SHALL guarantee bounded wait: a held request is granted within NUM_REQ cycles.

Reset
REQ-024 SHALL, while i_rst is low, asynchronously force rd=0, rd_write_control=0, rd_write_val=0 and rr_ptr=0.
REQ-025 SHALL hold req_ready all-zero while i_rst is low.
REQ-026 SHALL lose any transfer in flight when reset is asserted; no write reaches the register file for it.
REQ-027 SHALL re-arbitrate from rr_ptr=0 on the first clock edge after i_rst deasserts.

Configuration
REQ-028 SHALL add, when macro REGFILE_WB_PERF_EN is defined, output wait_cnt (NUM_REQ x 16).
REQ-029 SHALL, with REGFILE_WB_PERF_EN defined, increment wait_cnt[i] (saturating at 16'hFFFF) each cycle req_valid[i] is high and req_ready[i] is low.
REQ-030 SHALL clear wait_cnt to 0 on reset when REGFILE_WB_PERF_EN is defined.
REQ-031 SHALL, without REGFILE_WB_PERF_EN, have no wait_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-032 SHALL place the default NUM_REQ and XLEN, the requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_CSR=2) and a wb_req_t struct {rd[4:0], data[XLEN-1:0]} in shared package riscv_pkg.
REQ-033 SHALL instantiate one sub-module rr_arbiter (NUM_REQ, req vector in, one-hot grant out, internal pointer with advance-on-grant), reusable elsewhere in the core.

Verification
REQ-034 SHALL cover single request: req_valid=3'b001, rd=5, data=32'hDEADBEEF -> req_ready=3'b001 the same cycle; next cycle rd=5, rd_write_control=1, rd_write_val=32'hDEADBEEF.
REQ-035 SHALL cover three-way contention: all valid, held from reset -> grants 0,1,2 on consecutive cycles; conflict=1 for the first two cycles.
REQ-036 SHALL cover wrap-around: rr_ptr=2, valid=3'b011 -> grant 0, then grant 1; rr_ptr ends at 2.
REQ-037 SHALL cover x0 discard: requester 1 with rd=0, data=32'h1234 -> ready=1; next cycle rd_write_control=0.
REQ-038 SHALL cover reset mid-operation: i_rst low in the cycle after a grant -> outputs 0 immediately; no write; first grant after release goes to requester 0.
REQ-039 SHALL cover the PERF build: with REGFILE_WB_PERF_EN, requester 2 waits 2 cycles in three-way contention -> wait_cnt[2]=2, wait_cnt[0]=0.
